stream_mux_arb: RTL and testbench
=================================

# stream_mux_arb

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes and built-in arbitration, replacing fixed 4:1 gate-level select muxes where several producers share one consumer. Each cycle at most one requesting input channel is granted. Its data and channel index are captured into a one-entry output register. Arbitration mode is round-robin or fixed priority, selected by parameter.

## Interface
- `NCH`, 4: number of input channels, at least 2.
- `WIDTH`, 8: data width per channel, at least 1.
- `MODE`, 0: 0 is round-robin, 1 is fixed priority with channel 0 highest.
- `CW`, derived as max(1, ceil(log2(NCH))): channel index width; not user-set.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  NCH  per-channel request; bit i belongs to channel i.
- `in_data`  in  NCH*WIDTH  packed data; channel i occupies [i*WIDTH +: WIDTH].
- `in_ready`  out  NCH  per-channel accept, one-hot or zero.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  WIDTH  registered data of the held beat.
- `out_ch`  out  CW  index of the source channel of the held beat.

## Operation
- Transfer on an input channel: `in_valid[i] & in_ready[i]`. Transfer on the output: `out_valid & out_ready`.
- `can_load = !out_valid | out_ready`.
- Grant (combinational), among channels with `in_valid` set:
  - MODE 0: the first channel found scanning upward from `ptr`, wrapping from NCH-1 to 0.
  - MODE 1: the lowest-index requesting channel.
- `in_ready[i] = grant[i] & can_load`. `in_ready` depends on `in_valid` and `out_ready`; this combinational path is accepted. When no channel requests, `in_ready` is all zeros.
- On an input transfer from channel g:
  - `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`.
  - MODE 0 only: `ptr <= (g == NCH-1) ? 0 : g+1`.
- If the output transfers and no input transfers in the same cycle, `out_valid <= 0`. `out_data` and `out_ch` keep their last values.
- An output transfer and an input transfer in the same cycle: the register reloads with the new beat and `out_valid` stays 1. No bubble is inserted.
- Stall (`out_valid & !out_ready`): `out_data` and `out_ch` are held stable, `in_ready` is all zeros, and `ptr` is unchanged.
- `ptr` (CW bits) advances only on an input transfer. It never takes a value ≥ NCH. In MODE 1 it stays at 0.
- Producers may drop `in_valid` without a transfer. The arbiter holds no lock, so the grant is re-evaluated every cycle.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `ptr = 0`. While `rst` is high, `in_ready` is forced to all zeros.
- Reset mid-stall: a held beat is discarded. The first cycle after `rst` falls behaves as an empty buffer.
- Latency: 1 cycle from an input transfer to `out_valid` / `out_data`.
- Throughput: 1 beat per cycle while `out_ready` stays high.
- Fairness:
  - MODE 0: with all NCH channels continuously valid and `out_ready` = 1, grants cycle 0, 1, …, NCH-1, 0, … Each requesting channel waits at most NCH-1 grants.
  - MODE 1: starvation of lower-priority channels is permitted.

## Structure
- Shared package/include `stream_mux_pkg` holds the constants `MODE_RR = 0` and `MODE_FIXED = 1`, plus the `CW` clog2 helper function.
- One sub-module, `rr_arbiter`:
  - Parameters NCH and MODE.
  - Inputs `req[NCH]` and `ptr[CW]`.
  - Outputs one-hot `grant[NCH]`, `grant_idx[CW]` and `any_grant`.
  - Purely combinational.
- The top level holds `ptr`, the output register and the handshake logic.

## Test plan
- **Reset:** assert `rst` mid-stall with `out_valid` = 1 → next cycle `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `in_ready` = 0; after release, the first grant with all channels valid goes to channel 0.
- **Round-robin, full load:** MODE 0, NCH = 4, WIDTH = 8, `in_data` = {8'hD3, 8'hC2, 8'hB1, 8'hA0}, `in_valid` = 4'b1111, `out_ready` = 1 → on consecutive cycles `out_ch` = 0, 1, 2, 3, 0 and `out_data` = A0, B1, C2, D3, A0.
- **Round-robin, sparse with wrap:** `in_valid` = 4'b1001, `ptr` = 0 → grants 0, 3, 0, 3; with `in_valid` = 4'b0100 only, `ptr` goes 3 → grant 2 → `ptr` = 3.
- **Fixed priority:** MODE 1, `in_valid` = 4'b1110 held → `out_ch` = 1 on every beat; channels 2 and 3 never see `in_ready` while channel 1 stays valid.
- **Backpressure:** `out_ready` = 0 for 3 cycles after a beat is loaded from channel 2 → `out_data` and `out_ch` stable, `in_ready` = 0; `out_ready` = 1 with channel 3 valid → same-cycle handoff, `out_valid` stays 1 and `out_ch` = 3 on the next cycle.
- **Idle and edge parameters:** `in_valid` = 0 with `out_ready` = 1 → `out_valid` falls after one cycle and `ptr` is unchanged; repeat with NCH = 2, CW = 1 and with NCH = 5 to check the wrap from 4 to 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
// Shared constants and helpers for the stream multiplexer/arbiter slice.
//   MODE_RR    : round-robin arbitration, starting point rotates after each grant
//   MODE_FIXED : fixed priority, channel 0 always wins
//   calcCw()   : channel index width, never narrower than one bit
// ---------------------------------------------------------------------------
package stream_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // A two-channel mux still needs one index bit, and a degenerate
    // single-channel build must not produce a zero-width bus.
    function automatic int calcCw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational single-grant arbiter.
//   req       : per-channel request, bit i is channel i
//   ptr       : round-robin start index (ignored in fixed-priority mode)
//   grant     : one-hot grant, zero when nobody requests
//   grant_idx : binary index of the granted channel
//   any_grant : at least one channel was granted
// ---------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int MODE = MODE_RR,
    localparam int CW   = calcCw(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  grant_idx,
    output logic           any_grant
);

    logic [CW-1:0] startIdx;

    // Fixed priority is simply a round-robin scan that always starts at 0.
    assign startIdx = (MODE == MODE_FIXED) ? '0 : ptr;

    // The wrapping scan is split into two upward passes: first the channels
    // at or above the start index, then (only if nothing was found) the
    // whole vector from 0, which covers the channels below the start.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!any_grant && req[i] && (CW'(i) >= startIdx)) begin
                grant[i]  = 1'b1;
                grant_idx = CW'(i);
                any_grant = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!any_grant && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = CW'(i);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// ---------------------------------------------------------------------------
// stream_mux_arb
// N-channel registered stream multiplexer with built-in arbitration.
// One requesting channel is granted per cycle and its beat is captured in a
// single-entry output register; a full register that is being drained in the
// same cycle reloads without a bubble.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : per-channel request
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready  : per-channel accept, one-hot or zero
//   out_valid : output register holds a beat
//   out_ready : consumer accepts the held beat
//   out_data  : data of the held beat
//   out_ch    : source channel of the held beat
// ---------------------------------------------------------------------------
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int WIDTH = 8,
    parameter  int MODE  = MODE_RR,
    localparam int CW    = calcCw(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_ch
);

    logic [NCH-1:0]   grant;
    logic [CW-1:0]    grantIdx;
    logic             anyGrant;
    logic             canLoad;
    logic             inXfer;
    logic [WIDTH-1:0] selData;

    logic [CW-1:0]    ptr_q, ptr_d;
    logic             outValid_q;
    logic [WIDTH-1:0] outData_q;
    logic [CW-1:0]    outCh_q;

    rr_arbiter #(
        .NCH  (NCH),
        .MODE (MODE)
    ) uArbiter (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grantIdx),
        .any_grant (anyGrant)
    );

    // The register can take a new beat when empty or when its current beat
    // leaves this cycle. Reset masks every accept so no beat is lost.
    assign canLoad  = !outValid_q || out_ready;
    assign inXfer   = anyGrant && canLoad && !rst;
    assign in_ready = inXfer ? grant : '0;

    // One-hot AND-OR select of the granted channel's data.
    always_comb begin
        selData = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                selData = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pointer moves just past the winner; it wraps explicitly
    // so it never reaches NCH even when NCH is not a power of two.
    always_comb begin
        ptr_d = ptr_q;
        if ((MODE == MODE_RR) && inXfer) begin
            ptr_d = (grantIdx == CW'(NCH-1)) ? '0 : grantIdx + CW'(1);
        end
    end

    // Output register: load on an input transfer, otherwise empty out when
    // the consumer takes the beat. Data and channel persist after draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outCh_q    <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (inXfer) begin
                outValid_q <= 1'b1;
                outData_q  <= selData;
                outCh_q    <= grantIdx;
            end else if (out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_ch    = outCh_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_arb
// Four instances share one stimulus: NCH=4 round-robin, NCH=4 fixed priority,
// NCH=2 round-robin and NCH=5 round-robin. Narrower instances see the low
// slices of the shared valid/data buses.
// ---------------------------------------------------------------------------
module tb_stream_mux_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  inValid;
    logic [39:0] inData;
    logic        outReady;

    logic [3:0] ir0, ir1;
    logic [1:0] ir2;
    logic [4:0] ir3;
    logic       ov0, ov1, ov2, ov3;
    logic [7:0] od0, od1, od2, od3;
    logic [1:0] och0, och1;
    logic [0:0] och2;
    logic [2:0] och3;

    int tests = 0;
    int fails = 0;

    // Behavioural model state, one slot per instance.
    int nCh[4]    = '{4, 4, 2, 5};
    int modeOf[4] = '{0, 1, 0, 0};
    int mValid[4] = '{0, 0, 0, 0};
    int mData[4]  = '{0, 0, 0, 0};
    int mCh[4]    = '{0, 0, 0, 0};
    int mPtr[4]   = '{0, 0, 0, 0};
    int gM;

    int expCh0[6] = '{0, 1, 2, 3, 0, 1};
    int expCh2[6] = '{0, 1, 0, 1, 0, 1};
    int expCh5[6] = '{0, 1, 2, 3, 4, 0};

    always #5 clk = ~clk;

    stream_mux_arb #(.NCH(4), .WIDTH(8), .MODE(0)) dutRr4 (
        .clk(clk), .rst(rst), .in_valid(inValid[3:0]), .in_data(inData[31:0]),
        .in_ready(ir0), .out_valid(ov0), .out_ready(outReady), .out_data(od0), .out_ch(och0)
    );
    stream_mux_arb #(.NCH(4), .WIDTH(8), .MODE(1)) dutFix4 (
        .clk(clk), .rst(rst), .in_valid(inValid[3:0]), .in_data(inData[31:0]),
        .in_ready(ir1), .out_valid(ov1), .out_ready(outReady), .out_data(od1), .out_ch(och1)
    );
    stream_mux_arb #(.NCH(2), .WIDTH(8), .MODE(0)) dutRr2 (
        .clk(clk), .rst(rst), .in_valid(inValid[1:0]), .in_data(inData[15:0]),
        .in_ready(ir2), .out_valid(ov2), .out_ready(outReady), .out_data(od2), .out_ch(och2)
    );
    stream_mux_arb #(.NCH(5), .WIDTH(8), .MODE(0)) dutRr5 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData),
        .in_ready(ir3), .out_valid(ov3), .out_ready(outReady), .out_data(od3), .out_ch(och3)
    );

    // Winner under the arbitration rules: scan upward from the start point
    // with wrap-around, or from 0 in fixed priority. -1 when nobody asks.
    function automatic int pick(input int j);
        int start;
        start = (modeOf[j] == 1) ? 0 : mPtr[j];
        for (int k = 0; k < nCh[j]; k++) begin
            if (inValid[(start + k) % nCh[j]]) return (start + k) % nCh[j];
        end
        return -1;
    endfunction

    function automatic int expReady(input int j);
        int g;
        g = pick(j);
        if (rst || g < 0) return 0;
        if (mValid[j] == 0 || outReady) return 1 << g;
        return 0;
    endfunction

    // Model advances on the same edge as the design, using the inputs that
    // were stable across that edge.
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (rst) begin
                mValid[j] = 0;
                mData[j]  = 0;
                mCh[j]    = 0;
                mPtr[j]   = 0;
            end else if ((mValid[j] == 0 || outReady) && pick(j) >= 0) begin
                gM        = pick(j);
                mValid[j] = 1;
                mData[j]  = int'(inData[gM*8 +: 8]);
                mCh[j]    = gM;
                if (modeOf[j] == 0) mPtr[j] = (gM + 1) % nCh[j];
            end else if (mValid[j] != 0 && outReady) begin
                mValid[j] = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmpInst(input int j, input logic v, input logic [7:0] d,
                           input logic [31:0] ch, input logic [31:0] rdy);
        checkOutput($sformatf("dut%0d out_valid", j), {31'd0, v}, mValid[j]);
        checkOutput($sformatf("dut%0d out_data", j), {24'd0, d}, mData[j]);
        checkOutput($sformatf("dut%0d out_ch", j), ch, mCh[j]);
        checkOutput($sformatf("dut%0d in_ready", j), rdy, expReady(j));
    endtask

    // Every instance is compared against the model on every falling edge.
    always @(negedge clk) begin
        cmpInst(0, ov0, od0, {30'd0, och0}, {28'd0, ir0});
        cmpInst(1, ov1, od1, {30'd0, och1}, {28'd0, ir1});
        cmpInst(2, ov2, od2, {31'd0, och2}, {30'd0, ir2});
        cmpInst(3, ov3, od3, {29'd0, och3}, {27'd0, ir3});
    end

    task automatic applyStimulus(input logic r, input logic [4:0] v, input logic o);
        rst      = r;
        inValid  = v;
        outReady = o;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        inData = {8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0};
        applyStimulus(1'b1, 5'b00000, 1'b0);
        step();
        step();
        checkOutput("reset out_valid", {31'd0, ov0}, 0);
        checkOutput("reset out_data", {24'd0, od0}, 0);
        checkOutput("reset out_ch", {30'd0, och0}, 0);

        // Full load: every channel valid, consumer always ready.
        applyStimulus(1'b0, 5'b11111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput($sformatf("rr4 full ch[%0d]", i), {30'd0, och0}, expCh0[i]);
            checkOutput($sformatf("rr4 full data[%0d]", i), {24'd0, od0}, 32'hA0 + 32'h11 * expCh0[i]);
            checkOutput($sformatf("rr2 full ch[%0d]", i), {31'd0, och2}, expCh2[i]);
            checkOutput($sformatf("rr5 full ch[%0d]", i), {29'd0, och3}, expCh5[i]);
            checkOutput($sformatf("fix4 full ch[%0d]", i), {30'd0, och1}, 0);
        end

        // Stall, then reset while a beat is held.
        applyStimulus(1'b0, 5'b11111, 1'b0);
        step();
        checkOutput("stall out_valid", {31'd0, ov0}, 1);
        applyStimulus(1'b1, 5'b11111, 1'b0);
        step();
        checkOutput("midreset out_valid", {31'd0, ov0}, 0);
        checkOutput("midreset out_data", {24'd0, od0}, 0);
        checkOutput("midreset out_ch", {30'd0, och0}, 0);
        checkOutput("midreset in_ready", {28'd0, ir0}, 0);
        applyStimulus(1'b0, 5'b01111, 1'b1);
        step();
        checkOutput("postreset ch", {30'd0, och0}, 0);
        checkOutput("postreset data", {24'd0, od0}, 32'hA0);

        // Sparse requests with wrap, starting from a fresh pointer.
        applyStimulus(1'b1, 5'b00000, 1'b1);
        step();
        applyStimulus(1'b0, 5'b01001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("sparse ch[%0d]", i), {30'd0, och0}, (i % 2 == 0) ? 0 : 3);
        end
        applyStimulus(1'b0, 5'b00100, 1'b1);
        step();
        checkOutput("solo2 first ch", {30'd0, och0}, 2);
        step();
        checkOutput("solo2 second ch", {30'd0, och0}, 2);
        checkOutput("model ptr after solo2", mPtr[0], 3);
        applyStimulus(1'b0, 5'b11111, 1'b1);
        step();
        checkOutput("after solo2 ch", {30'd0, och0}, 3);
        checkOutput("after solo2 data", {24'd0, od0}, 32'hD3);

        // Fixed priority: channel 1 always wins over 2 and 3.
        applyStimulus(1'b0, 5'b01110, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("fix ch[%0d]", i), {30'd0, och1}, 1);
            checkOutput($sformatf("fix in_ready[%0d]", i), {28'd0, ir1}, 32'h2);
        end

        // Backpressure with a same-cycle handoff on release.
        applyStimulus(1'b0, 5'b00100, 1'b1);
        step();
        checkOutput("bp load ch", {30'd0, och0}, 2);
        applyStimulus(1'b0, 5'b01000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("bp valid[%0d]", i), {31'd0, ov0}, 1);
            checkOutput($sformatf("bp ch[%0d]", i), {30'd0, och0}, 2);
            checkOutput($sformatf("bp data[%0d]", i), {24'd0, od0}, 32'hC2);
            checkOutput($sformatf("bp in_ready[%0d]", i), {28'd0, ir0}, 0);
        end
        applyStimulus(1'b0, 5'b01000, 1'b1);
        #1;
        checkOutput("handoff in_ready", {28'd0, ir0}, 32'h8);
        step();
        checkOutput("handoff valid", {31'd0, ov0}, 1);
        checkOutput("handoff ch", {30'd0, och0}, 3);
        checkOutput("handoff data", {24'd0, od0}, 32'hD3);

        // Idle: output drains and the pointer is left where it was.
        applyStimulus(1'b0, 5'b00010, 1'b1);
        step();
        checkOutput("preidle ch", {30'd0, och0}, 1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        step();
        checkOutput("idle valid rr4", {31'd0, ov0}, 0);
        checkOutput("idle valid rr5", {31'd0, ov3}, 0);
        checkOutput("idle in_ready", {28'd0, ir0}, 0);
        step();
        applyStimulus(1'b0, 5'b11111, 1'b1);
        step();
        checkOutput("postidle valid", {31'd0, ov0}, 1);
        checkOutput("postidle ch", {30'd0, och0}, 2);
        checkOutput("model ch postidle", mCh[0], 2);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
